// File: rtl/ibex_pkg.sv
// Shared types and constants for the branch-prediction resolve path.
package ibex_pkg;

  localparam logic [31:0] BP_INSTR_STEP_16 = 32'd2;
  localparam logic [31:0] BP_INSTR_STEP_32 = 32'd4;

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
    logic [31:0] pc;
  } bp_entry_t;

  // Sequential PC after a branch; wraps modulo 2^32.
  function automatic logic [31:0] bp_fall_through(input logic [31:0] pc, input logic compressed);
    return pc + (compressed ? BP_INSTR_STEP_16 : BP_INSTR_STEP_32);
  endfunction

endpackage

// File: rtl/ibex_branch_resolve_if.sv
// Predict/resolve/redirect bus between the IF predictor, EX branch unit and resolver.
interface ibex_branch_resolve_if;
  logic        predict_valid_i;
  logic        predict_taken_i;
  logic [31:0] predict_target_i;
  logic [31:0] predict_pc_i;
  logic        predict_ready_o;
  logic        resolve_valid_i;
  logic        resolve_taken_i;
  logic [31:0] resolve_target_i;
  logic [31:0] resolve_pc_i;
  logic        resolve_compressed_i;
  logic        flush_i;
  logic        mispredict_o;
  logic [31:0] redirect_pc_o;
  logic        tag_error_o;
  logic [31:0] perf_branch_cnt_o;
  logic [31:0] perf_mispredict_cnt_o;

  modport master (
    output predict_valid_i, predict_taken_i, predict_target_i, predict_pc_i,
    output resolve_valid_i, resolve_taken_i, resolve_target_i, resolve_pc_i,
    output resolve_compressed_i, flush_i,
    input  predict_ready_o, mispredict_o, redirect_pc_o, tag_error_o,
    input  perf_branch_cnt_o, perf_mispredict_cnt_o
  );

  modport slave (
    input  predict_valid_i, predict_taken_i, predict_target_i, predict_pc_i,
    input  resolve_valid_i, resolve_taken_i, resolve_target_i, resolve_pc_i,
    input  resolve_compressed_i, flush_i,
    output predict_ready_o, mispredict_o, redirect_pc_o, tag_error_o,
    output perf_branch_cnt_o, perf_mispredict_cnt_o
  );
endinterface

// File: rtl/ibex_bp_queue.sv
// In-order circular FIFO of outstanding predictions; the extra pointer bit
// separates full from empty.
module ibex_bp_queue
  import ibex_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  logic      pop,
  input  logic      clear,
  input  bp_entry_t wdata,
  output bp_entry_t rdata,
  output logic      empty,
  output logic      full
);
  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] wr_ptr, rd_ptr;
  bp_entry_t     mem [Depth];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < int'(Depth); i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        mem[wr_ptr[AW-1:0]] <= wdata;
        wr_ptr              <= wr_ptr + PW'(1);
      end
      if (pop && !empty) rd_ptr <= rd_ptr + PW'(1);
    end
  end
endmodule

// File: rtl/ibex_branch_resolve.sv
// Compares queued predictions against execute-stage outcomes and issues redirects.
// Optional accuracy counters: define IBEX_BP_PERF_COUNTERS_EN.
module ibex_branch_resolve
  import ibex_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  ibex_branch_resolve_if.slave bus
);
  bp_entry_t in_entry, q_head, head;
  logic      q_empty, q_full;
  logic      bypass, have_entry, tag_bad, mp_now, te_now, resolve_fire;
  logic      push, pop, clear;
  logic [31:0] redirect_now;

  assign in_entry = '{taken:  bus.predict_taken_i,
                      target: bus.predict_target_i,
                      pc:     bus.predict_pc_i};

  assign bus.predict_ready_o = !q_full;

  // An empty queue lets a same-cycle prediction be judged without storing it.
  assign bypass     = bus.resolve_valid_i && q_empty && bus.predict_valid_i;
  assign head       = bypass ? in_entry : q_head;
  assign have_entry = !q_empty || bypass;

  assign resolve_fire = bus.resolve_valid_i && !bus.flush_i;
  assign tag_bad      = !have_entry || (head.pc != bus.resolve_pc_i);
  assign te_now       = resolve_fire && tag_bad;
  // A missing entry behaves as a not-taken prediction with a bad tag.
  assign mp_now = resolve_fire &&
                  (tag_bad ||
                   (head.taken != bus.resolve_taken_i) ||
                   (head.taken && bus.resolve_taken_i && (head.target != bus.resolve_target_i)));

  assign redirect_now = bus.resolve_taken_i ? bus.resolve_target_i
                                            : bp_fall_through(bus.resolve_pc_i, bus.resolve_compressed_i);

  assign clear = bus.flush_i || mp_now;
  assign pop   = resolve_fire && !q_empty;
  assign push  = bus.predict_valid_i && !q_full && !bypass && !clear;

  ibex_bp_queue #(.Depth(Depth)) u_queue (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .push  (push),
    .pop   (pop),
    .clear (clear),
    .wdata (in_entry),
    .rdata (q_head),
    .empty (q_empty),
    .full  (q_full)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bus.mispredict_o  <= 1'b0;
      bus.redirect_pc_o <= '0;
      bus.tag_error_o   <= 1'b0;
    end else begin
      bus.mispredict_o  <= mp_now;
      bus.redirect_pc_o <= mp_now ? redirect_now : '0;
      bus.tag_error_o   <= te_now;
    end
  end

`ifdef IBEX_BP_PERF_COUNTERS_EN
  logic [31:0] branch_cnt, mispredict_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else begin
      if (resolve_fire && (branch_cnt != '1))  branch_cnt     <= branch_cnt + 32'd1;
      if (mp_now && (mispredict_cnt != '1))    mispredict_cnt <= mispredict_cnt + 32'd1;
    end
  end

  assign bus.perf_branch_cnt_o     = branch_cnt;
  assign bus.perf_mispredict_cnt_o = mispredict_cnt;
`else
  assign bus.perf_branch_cnt_o     = '0;
  assign bus.perf_mispredict_cnt_o = '0;
`endif
endmodule

// File: tb/tb_ibex_branch_resolve.sv
// Directed vectors for the branch resolver; expected redirects go through a scoreboard queue.
module tb_ibex_branch_resolve;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ibex_branch_resolve_if bus();

  ibex_branch_resolve #(.Depth(2)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  typedef struct {
    logic        mp;
    logic [31:0] pc;
    logic        te;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   bcnt   = 0;
  int   mcnt   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_cnt(input string name);
`ifdef IBEX_BP_PERF_COUNTERS_EN
    chk({name, "_bcnt"}, bus.perf_branch_cnt_o, 32'(bcnt));
    chk({name, "_mcnt"}, bus.perf_mispredict_cnt_o, 32'(mcnt));
`else
    chk({name, "_bcnt"}, bus.perf_branch_cnt_o, 32'd0);
    chk({name, "_mcnt"}, bus.perf_mispredict_cnt_o, 32'd0);
`endif
  endtask

  task automatic drive(input logic pv, input logic pt, input logic [31:0] ptg, input logic [31:0] ppc,
                       input logic rv, input logic rt, input logic [31:0] rtg, input logic [31:0] rpc,
                       input logic rc, input logic fl,
                       input logic emp, input logic [31:0] epc, input logic ete);
    exp_t e;
    @(negedge clk);
    bus.predict_valid_i      = pv;
    bus.predict_taken_i      = pt;
    bus.predict_target_i     = ptg;
    bus.predict_pc_i         = ppc;
    bus.resolve_valid_i      = rv;
    bus.resolve_taken_i      = rt;
    bus.resolve_target_i     = rtg;
    bus.resolve_pc_i         = rpc;
    bus.resolve_compressed_i = rc;
    bus.flush_i              = fl;
    if (rv) begin
      e.mp = emp; e.pc = emp ? epc : 32'd0; e.te = ete;
      sb.push_back(e);
      if (!fl) bcnt++;
      if (emp) mcnt++;
    end
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic predict(input logic pt, input logic [31:0] ptg, input logic [31:0] ppc);
    drive(1, pt, ptg, ppc, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic resolve(input logic rt, input logic [31:0] rtg, input logic [31:0] rpc, input logic rc,
                         input logic emp, input logic [31:0] epc, input logic ete);
    drive(0, 0, 0, 0, 1, rt, rtg, rpc, rc, 0, emp, epc, ete);
  endtask

  // Monitor: a resolve sampled at an edge must show its response one cycle later.
  initial begin
    logic fired;
    exp_t e;
    forever begin
      @(posedge clk);
      fired = bus.resolve_valid_i && rst_n;
      @(negedge clk);
      if (fired) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("mispredict", {31'd0, bus.mispredict_o}, {31'd0, e.mp});
          chk("redirect_pc", bus.redirect_pc_o, e.pc);
          chk("tag_error", {31'd0, bus.tag_error_o}, {31'd0, e.te});
        end
      end else begin
        chk("idle_mispredict", {31'd0, bus.mispredict_o}, 32'd0);
        chk("idle_tag_error", {31'd0, bus.tag_error_o}, 32'd0);
      end
    end
  end

  initial begin
    bus.predict_valid_i = 0; bus.predict_taken_i = 0; bus.predict_target_i = 0; bus.predict_pc_i = 0;
    bus.resolve_valid_i = 0; bus.resolve_taken_i = 0; bus.resolve_target_i = 0; bus.resolve_pc_i = 0;
    bus.resolve_compressed_i = 0; bus.flush_i = 0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, bus.predict_ready_o}, 32'd1);
    chk("rst_mispredict", {31'd0, bus.mispredict_o}, 32'd0);
    chk("rst_redirect", bus.redirect_pc_o, 32'd0);
    chk("rst_tag_error", {31'd0, bus.tag_error_o}, 32'd0);
    chk_cnt("rst");
    rst_n = 1'b1;

    // Correct taken prediction
    predict(1, 32'h80, 32'h100);
    resolve(1, 32'h80, 32'h100, 0, 0, 0, 0);
    idle();
    chk_cnt("correct");

    // Predicted not-taken, actually taken
    predict(0, 32'h204, 32'h200);
    resolve(1, 32'h300, 32'h200, 0, 1, 32'h300, 0);
    idle();
    chk_cnt("nt_taken");

    // Predicted taken, actually not-taken: compressed and wrapping fall-through
    predict(1, 32'h500, 32'h400);
    resolve(0, 32'h0, 32'h400, 1, 1, 32'h402, 0);
    predict(1, 32'h10, 32'hFFFF_FFFC);
    resolve(0, 32'h0, 32'hFFFF_FFFC, 0, 1, 32'h0, 0);
    idle();

    // Fill, drop a push while full, then clear on mispredict
    predict(0, 0, 32'h600);
    predict(0, 0, 32'h604);
    predict(0, 0, 32'h608);
    chk("full_ready", {31'd0, bus.predict_ready_o}, 32'd0);
    resolve(1, 32'h700, 32'h600, 0, 1, 32'h700, 0);
    chk("full_drop_ready", {31'd0, bus.predict_ready_o}, 32'd0);
    idle();
    chk("clear_ready", {31'd0, bus.predict_ready_o}, 32'd1);
    resolve(0, 0, 32'h604, 0, 1, 32'h608, 1);
    idle();

    // Empty queue without and with a same-cycle push
    resolve(0, 0, 32'h800, 0, 1, 32'h804, 1);
    drive(1, 1, 32'h900, 32'h880, 1, 1, 32'h900, 32'h880, 0, 0, 0, 0, 0);
    resolve(0, 0, 32'h884, 0, 1, 32'h888, 1);
    idle();
    chk_cnt("bypass");

    // Flush wins over a mismatching resolve
    predict(0, 0, 32'hA00);
    drive(0, 0, 0, 0, 1, 1, 32'hB00, 32'hA00, 0, 1, 0, 0, 0);
    idle();
    chk_cnt("flush");
    chk("flush_ready", {31'd0, bus.predict_ready_o}, 32'd1);
    resolve(0, 0, 32'hA00, 0, 1, 32'hA04, 1);

    // Tag mismatch on a non-empty queue
    predict(0, 0, 32'hC00);
    resolve(0, 0, 32'hC04, 0, 1, 32'hC08, 1);

    // Simultaneous push and pop keeps occupancy
    predict(0, 0, 32'hD00);
    drive(1, 1, 32'hE00, 32'hD10, 1, 0, 0, 32'hD00, 0, 0, 0, 0, 0);
    resolve(1, 32'hE00, 32'hD10, 0, 0, 0, 0);
    chk("pushpop_ready", {31'd0, bus.predict_ready_o}, 32'd1);
    idle();
    chk_cnt("pushpop");

    // Asynchronous reset mid-operation drops the queued entry
    predict(0, 0, 32'hF00);
    idle();
    #2 rst_n = 1'b0;
    bcnt = 0; mcnt = 0;
    #1;
    chk("mid_rst_ready", {31'd0, bus.predict_ready_o}, 32'd1);
    chk("mid_rst_redirect", bus.redirect_pc_o, 32'd0);
    chk_cnt("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    resolve(0, 0, 32'hF00, 0, 1, 32'hF04, 1);
    idle();
    chk_cnt("post_rst");

    repeat (3) idle();
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
